// File: rtl/adder_pkg.sv
// Shared constants, slice result type and configuration check for pipelined_adder.
package adder_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_SEG    = 64;

  // Slice sum is padded to MAX_SEG; only the low SEG bits are meaningful.
  typedef struct packed {
    logic               carry;
    logic [MAX_SEG-1:0] sum;
  } slice_res_t;

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) &&
           (width % stages == 0) && (width / stages <= MAX_SEG);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// slave = adder side, master = producer/consumer side.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] adder_inA;
  logic [WIDTH-1:0] adder_inB;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, adder_inA, adder_inB, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, adder_inA, adder_inB, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/adder_slice.sv
// Purpose: SEG-bit add of two slices plus carry-in.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage handles stalls.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output slice_res_t     res
);
  logic [SEG:0] full;

  always_comb begin
    full               = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    res                = '0;
    res.sum[SEG-1:0]   = full[SEG-1:0];
    res.carry          = full[SEG];
  end
endmodule

// File: rtl/pipelined_adder.sv
// Purpose: two's-complement add/sub, carry rippled one slice per stage; flags built when ADDER_FLAGS_EN is defined.
// Latency: STAGES cycles from accept to out_valid.
// Backpressure: global stall, in_ready = out_ready || !out_valid; every stage holds together.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int L   = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must split evenly into 1..%0d stages of <= %0d bits",
           MAX_STAGES, MAX_SEG);
  end

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  assign advance      = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = advance;
  assign eff_b        = bus.sub ? ~bus.adder_inB : bus.adder_inB;
  assign eff_cin      = bus.sub || bus.cin;

  // Stage k keeps the not-yet-added upper operand bits and the finished lower sum bits.
  for (genvar k = 0; k < L; k++) begin : g_mid
    localparam int CUR  = WIDTH - k * SEG;
    localparam int DONE = (k + 1) * SEG;

    logic [CUR-1:0]        a_cur, b_cur;
    logic                  c_cur, v_cur;
    logic [DONE-1:0]       s_nxt;
    slice_res_t            res;
    logic                  unused_pad;
    logic                  v_q, c_q;
    logic [WIDTH-DONE-1:0] a_hi, b_hi;
    logic [DONE-1:0]       s_lo;

    if (k == 0) begin : g_src
      assign a_cur = bus.adder_inA;
      assign b_cur = eff_b;
      assign c_cur = eff_cin;
      assign v_cur = bus.in_valid;
      assign s_nxt = res.sum[SEG-1:0];
    end else begin : g_src
      assign a_cur = g_mid[k-1].a_hi;
      assign b_cur = g_mid[k-1].b_hi;
      assign c_cur = g_mid[k-1].c_q;
      assign v_cur = g_mid[k-1].v_q;
      assign s_nxt = {res.sum[SEG-1:0], g_mid[k-1].s_lo};
    end

    adder_slice #(.SEG(SEG)) u_slice (
      .a   (a_cur[SEG-1:0]),
      .b   (b_cur[SEG-1:0]),
      .cin (c_cur),
      .res (res)
    );
    assign unused_pad = ^res.sum;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        a_hi <= '0;
        b_hi <= '0;
        s_lo <= '0;
      end else if (advance) begin
        v_q  <= v_cur;
        c_q  <= res.carry;
        a_hi <= a_cur[CUR-1:SEG];
        b_hi <= b_cur[CUR-1:SEG];
        s_lo <= s_nxt;
      end
    end
  end

  logic [SEG-1:0]   a_l, b_l;
  logic             c_l, v_l;
  logic [WIDTH-1:0] sum_nxt;
  slice_res_t       res_l;
  logic             unused_pad_l;

  if (STAGES == 1) begin : g_last_src
    assign a_l     = bus.adder_inA;
    assign b_l     = eff_b;
    assign c_l     = eff_cin;
    assign v_l     = bus.in_valid;
    assign sum_nxt = res_l.sum[SEG-1:0];
  end else begin : g_last_src
    assign a_l     = g_mid[L-1].a_hi;
    assign b_l     = g_mid[L-1].b_hi;
    assign c_l     = g_mid[L-1].c_q;
    assign v_l     = g_mid[L-1].v_q;
    assign sum_nxt = {res_l.sum[SEG-1:0], g_mid[L-1].s_lo};
  end

  adder_slice #(.SEG(SEG)) u_slice_last (
    .a   (a_l),
    .b   (b_l),
    .cin (c_l),
    .res (res_l)
  );
  assign unused_pad_l = ^res_l.sum;

  logic             v_q, cout_q;
  logic [WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      cout_q <= 1'b0;
      sum_q  <= '0;
    end else if (advance) begin
      v_q    <= v_l;
      cout_q <= res_l.carry;
      sum_q  <= sum_nxt;
    end
  end

  assign bus.out_valid = v_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

`ifdef ADDER_FLAGS_EN
  logic ovf_q, zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      ovf_q  <= (a_l[SEG-1] == b_l[SEG-1]) && (res_l.sum[SEG-1] != a_l[SEG-1]);
      zero_q <= (sum_nxt == '0);
    end
  end

  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`else
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
`endif
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface, carry-propagation split across pipeline stages, and optional status flags. It replaces the single-register 32-bit adder wrapper in the ALU datapath: operands enter at the ALU issue point and results leave toward the writeback register. It sustains one operation per cycle at a clock rate set by the slice width rather than the full operand width.

## Interface
- WIDTH, 32: operand and result width in bits; must be divisible by STAGES.
- STAGES, 2: pipeline depth and carry-segment count (1..8); slice width SEG = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  pipeline accepts a beat this cycle.
- adder_inA  in  WIDTH  operand A.
- adder_inB  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A−B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (for subtract, 1 = no borrow).
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Subtract: B is replaced by ~B and the carry-in is forced to 1.
- Stage k (0-based) adds slice k of A and B plus the carry registered from stage k−1. Stage 0 uses the effective carry-in.
- Slices above k are carried forward unmodified in skew registers. Completed lower sum slices are carried forward in de-skew registers.
- The final stage holds the full sum and cout. For SEG==WIDTH (STAGES=1), this is a plain registered adder.
- overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective (possibly inverted) B. It is evaluated in the last stage.
- Handshake: a beat transfers on in_valid && in_ready. A result transfers on out_valid && out_ready.
- Global stall: advance = out_ready || !out_valid; in_ready = advance.
- When advance = 0, all stage registers, including the valid bits, hold.
- When advance = 1, every stage shifts. A stage whose valid bit is 0 shifts a bubble.
- Bubbles are not collapsed. A bubble consumes its pipeline slot.
- Results emerge in issue order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge n produces out_valid high after edge n+STAGES, provided advance was 1 on every intervening edge.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends combinationally on out_ready and out_valid. There is no combinational path from in_valid to in_ready.
- While out_valid=1 and out_ready=0, sum, cout, overflow and zero stay stable.
- Reset values: out_valid 0, sum 0, cout 0, overflow 0, zero 0. in_ready is 1 during and after reset. All internal valids, carries and data registers are 0.
- Reset asserted mid-stream clears all in-flight beats immediately (asynchronously). No partial result is emitted after deassertion.
- Simultaneous accept and emit in the same cycle is legal and is the steady state.

## Configuration
- ADDER_FLAGS_EN defined: overflow and zero are computed and registered as described above.
- ADDER_FLAGS_EN undefined: overflow and zero are tied to 0 and their logic is absent. The ports stay present, and sum, cout and timing are unchanged.

## Structure
- Package adder_pkg holds:
  - the MAX_STAGES constant (8);
  - a slice-result struct typedef (sum slice plus carry);
  - an elaboration check function that validates WIDTH % STAGES == 0.
- Sub-module adder_slice is a combinational SEG-bit add of two slices plus carry-in, giving a sum slice and carry-out. It is instantiated STAGES times via generate.
- All pipeline, skew and valid registers live in pipelined_adder.

## Test plan
- WIDTH=32, STAGES=4: 0xFFFFFFFF + 0x00000001, cin=0 → sum 0x00000000, cout 1, zero 1, overflow 0; out_valid exactly 4 cycles after accept.
- 0x7FFFFFFF + 0x00000001 → sum 0x80000000, cout 0, overflow 1. Then sub: 5 − 7 → sum 0xFFFFFFFE, cout 0, overflow 0.
- Stream 8 random beats back-to-back with out_ready held low for 3 cycles mid-stream → in_ready low exactly while stalled with out_valid=1; all 8 results correct and in order versus the reference model.
- Assert rst for 1 cycle with 3 beats in flight → out_valid 0 immediately and every output 0; the next accepted beat (1+2) yields sum 3 after 4 cycles with no stale output before it.
- STAGES=1 and STAGES=8 builds: 0x12345678 + 0x0FEDCBA8 → 0x22222220 at latency 1 and 8 respectively.
- Build without ADDER_FLAGS_EN and rerun the first two scenarios → overflow and zero constantly 0; sum and cout unchanged.
